// File: rtl/cla_adder_pipe.sv
// ---------------------------------------------------------------------------
// cla_adder_pipe
//
// Pipelined carry-lookahead adder/subtractor. The WIDTH-bit operands are cut
// into NB = WIDTH/BLK lookahead blocks, and each pipeline stage resolves one
// block. The carry out of block k is registered and becomes the carry in of
// block k+1 in the next stage. Operand bits that have not been used yet move
// forward with the beat, and so do the finished low-order sum bits.
// Both the input and the output side use a valid/ready handshake.
//
// Parameters
//   WIDTH      operand/result width; must be a multiple of BLK
//   BLK        bits per lookahead block (one block per stage)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   operand beat offered
//   in_ready   block accepts a beat this cycle
//   x, y       operands A and B
//   sub        0: x + y + cin, 1: x + ~y + 1 (cin ignored)
//   cin        carry in, add mode only
//   out_valid  result beat available
//   out_ready  downstream accepts result
//   sum        result, modulo 2^WIDTH
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//
// Optional build macro CLA_PIPE_FLAGS_EN adds three outputs, each registered
// together with sum:
//   ovf        signed overflow (carry into MSB xor carry out)
//   zero       sum == 0, built up as the AND of each block's zero test
//   neg        sum[WIDTH-1]
// ---------------------------------------------------------------------------
module cla_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_PIPE_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero,
    output logic             neg
`endif
);

    localparam int NB = WIDTH / BLK;

    // Expanded lookahead carries into bits 0..BLK-1 of one block:
    // c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1]..p[0]c0
    function automatic logic [BLK-1:0] lookahead(input logic [BLK-1:0] p,
                                                 input logic [BLK-1:0] g,
                                                 input logic           c0);
        logic [BLK-1:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int i = 1; i < BLK; i++) begin
            term = c0;
            for (int m = 0; m < i; m++) term = term & p[m];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) term = term & p[m];
                c[i] = c[i] | term;
            end
        end
        return c;
    endfunction

    // Block generate: G = g[BLK-1] | p[BLK-1]g[BLK-2] | ... | p[BLK-1..1]g[0]
    function automatic logic block_gen(input logic [BLK-1:0] p,
                                       input logic [BLK-1:0] g);
        logic acc;
        logic term;
        acc = 1'b0;
        for (int i = 0; i < BLK; i++) begin
            term = g[i];
            for (int m = i + 1; m < BLK; m++) term = term & p[m];
            acc = acc | term;
        end
        return acc;
    endfunction

    logic [NB-1:0] v;
    logic [NB-1:0] adv;

    genvar k;
    generate
        for (k = 0; k < NB; k++) begin : stage
            localparam int LO  = k * BLK;
            localparam int REM = WIDTH - LO;

            logic [REM-1:0]      x_in;
            logic [REM-1:0]      y_in;
            logic                c_in;
            logic                v_in;
            logic [LO+BLK-1:0]   s_next;
            logic [BLK-1:0]      p;
            logic [BLK-1:0]      g;
            logic [BLK-1:0]      car;
            logic [BLK-1:0]      blk_sum;
            logic                blk_g;
            logic                blk_p;
            logic                blk_c;
            logic                v_q;
            logic                c_q;
            logic [LO+BLK-1:0]   s_q;

            // Subtraction is folded in at the front: y is inverted once and the
            // block 0 carry-in is forced high, so later stages only ever add.
            if (k == 0) begin : g_src
                assign x_in   = x;
                assign y_in   = sub ? ~y : y;
                assign c_in   = sub | cin;
                assign v_in   = in_valid;
                assign s_next = blk_sum;
            end else begin : g_src
                assign x_in   = stage[k-1].g_skew.x_q;
                assign y_in   = stage[k-1].g_skew.y_q;
                assign c_in   = stage[k-1].c_q;
                assign v_in   = stage[k-1].v_q;
                assign s_next = {blk_sum, stage[k-1].s_q};
            end

            assign p       = x_in[BLK-1:0] ^ y_in[BLK-1:0];
            assign g       = x_in[BLK-1:0] & y_in[BLK-1:0];
            assign car     = lookahead(p, g, c_in);
            assign blk_sum = p ^ car;
            assign blk_g   = block_gen(p, g);
            assign blk_p   = &p;
            assign blk_c   = blk_g | (blk_p & c_in);

            // A stage may move when it, or any stage after it, is empty, or when
            // the sink takes the result. Writing it this way keeps in_ready a
            // flat function of out_ready and the valid bits.
            assign v[k]   = v_q;
            assign adv[k] = out_ready | ~(&v[NB-1:k]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    s_q <= '0;
                end else if (adv[k]) begin
                    v_q <= v_in;
                    if (v_in) begin
                        c_q <= blk_c;
                        s_q <= s_next;
                    end
                end
            end

            // Operand bits that later stages still need ride along with the beat.
            if (k < NB - 1) begin : g_skew
                logic [REM-BLK-1:0] x_q;
                logic [REM-BLK-1:0] y_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        x_q <= '0;
                        y_q <= '0;
                    end else if (adv[k] && v_in) begin
                        x_q <= x_in[REM-1:BLK];
                        y_q <= y_in[REM-1:BLK];
                    end
                end
            end

`ifdef CLA_PIPE_FLAGS_EN
            logic z_in;
            logic z_q;

            if (k == 0) begin : g_zsrc
                assign z_in = 1'b1;
            end else begin : g_zsrc
                assign z_in = stage[k-1].z_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    z_q <= 1'b0;
                end else if (adv[k] && v_in) begin
                    z_q <= z_in & ~(|blk_sum);
                end
            end

            // Only the top block can see the carry into the MSB.
            if (k == NB - 1) begin : g_ovf
                logic o_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        o_q <= 1'b0;
                    end else if (adv[k] && v_in) begin
                        o_q <= car[BLK-1] ^ blk_c;
                    end
                end
            end
`endif
        end
    endgenerate

    assign in_ready  = adv[0];
    assign out_valid = v[NB-1];
    assign sum       = stage[NB-1].s_q;
    assign cout      = stage[NB-1].c_q;

`ifdef CLA_PIPE_FLAGS_EN
    assign ovf  = stage[NB-1].g_ovf.o_q;
    assign zero = stage[NB-1].z_q;
    assign neg  = stage[NB-1].s_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_cla_adder_pipe.sv
// ---------------------------------------------------------------------------
// tb_cla_adder_pipe
//
// Self-checking bench for cla_adder_pipe (WIDTH=16, BLK=4, four stages).
// A queue-based reference model computes each accepted beat's result with
// plain integer arithmetic. A negedge monitor compares the DUT against the
// model on every cycle. Directed vectors pin literal expectations.
// Flag outputs are checked only when CLA_PIPE_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_cla_adder_pipe;

    localparam int WIDTH = 16;
    localparam int BLK   = 4;
    localparam int NB    = WIDTH / BLK;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [15:0] x         = '0;
    logic [15:0] y         = '0;
    logic        sub       = 1'b0;
    logic        cin       = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
`ifdef CLA_PIPE_FLAGS_EN
    logic        ovf;
    logic        zero;
    logic        neg;
`endif

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;

    logic [15:0] res_sum;
    logic        res_cout;
    logic        res_ovf;
    logic        res_zero;
    logic        res_neg;
    int          res_lat;

    cla_adder_pipe #(.WIDTH(WIDTH), .BLK(BLK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_PIPE_FLAGS_EN
        ,
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: unsigned result with carry, plus signed range test.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic s, input logic c);
        exp_t        e;
        int unsigned full;
        int          sa;
        if (!s) begin
            full   = int'(a) + int'(b) + int'(c);
            e.sum  = full[15:0];
            e.cout = full[16];
            sa     = int'($signed(a)) + int'($signed(b)) + int'(c);
        end else begin
            e.sum  = a - b;
            e.cout = (a >= b);
            sa     = int'($signed(a)) - int'($signed(b));
        end
        e.ovf  = (sa > 32767) || (sa < -32768);
        e.zero = (e.sum == 16'h0000);
        e.neg  = e.sum[15];
        return e;
    endfunction

    // Monitor: ready rule, output beat contents and ordering, no stale beats.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
        end else begin
            checkOutput("in_ready_rule", 32'(in_ready),
                        32'(!((exp_q.size() == NB) && !out_ready)));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("out_valid_with_nothing_in_flight", 32'(out_valid), 32'(0));
                end else begin
                    e = exp_q[0];
                    checkOutput("model_sum", 32'(sum), 32'(e.sum));
                    checkOutput("model_cout", 32'(cout), 32'(e.cout));
`ifdef CLA_PIPE_FLAGS_EN
                    checkOutput("model_ovf", 32'(ovf), 32'(e.ovf));
                    checkOutput("model_zero", 32'(zero), 32'(e.zero));
                    checkOutput("model_neg", 32'(neg), 32'(e.neg));
`endif
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(x, y, sub, cin));
        end
    end

    // One beat into an idle pipe; capture the result and the cycle count
    // from presenting the beat until out_valid.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic c);
        x         = a;
        y         = b;
        sub       = s;
        cin       = c;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        res_lat  = 1;
        while (!out_valid && res_lat < 20) begin
            @(posedge clk); #1;
            res_lat++;
        end
        res_sum  = sum;
        res_cout = cout;
`ifdef CLA_PIPE_FLAGS_EN
        res_ovf  = ovf;
        res_zero = zero;
        res_neg  = neg;
`else
        res_ovf  = 1'b0;
        res_zero = 1'b0;
        res_neg  = 1'b0;
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic        acc;
        logic        hold;
        logic [15:0] got[$];
        int          idx;
        int          n_acc;
        int          first_low;
        int          low_cnt;
        int          stale;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'(0));
        checkOutput("reset_sum", 32'(sum), 32'(0));
        checkOutput("reset_cout", 32'(cout), 32'(0));
        checkOutput("reset_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk); #1;

        // Plain add, latency check.
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
        checkOutput("add_sum", 32'(res_sum), 32'h5555);
        checkOutput("add_cout", 32'(res_cout), 32'(0));
        checkOutput("add_latency", 32'(res_lat), 32'(4));

        // Carry ripples through every block.
        applyStimulus(16'hFFFF, 16'h0000, 1'b0, 1'b1);
        checkOutput("ripple_sum", 32'(res_sum), 32'h0000);
        checkOutput("ripple_cout", 32'(res_cout), 32'(1));
`ifdef CLA_PIPE_FLAGS_EN
        checkOutput("ripple_zero", 32'(res_zero), 32'(1));
        checkOutput("ripple_ovf", 32'(res_ovf), 32'(0));
`endif

        // Subtract with borrow, then signed overflow on subtract.
        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b0);
        checkOutput("sub_borrow_sum", 32'(res_sum), 32'hFFFE);
        checkOutput("sub_borrow_cout", 32'(res_cout), 32'(0));
`ifdef CLA_PIPE_FLAGS_EN
        checkOutput("sub_borrow_neg", 32'(res_neg), 32'(1));
`endif
        applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b1);
        checkOutput("sub_ovf_sum", 32'(res_sum), 32'h7FFF);
        checkOutput("sub_ovf_cout", 32'(res_cout), 32'(1));
`ifdef CLA_PIPE_FLAGS_EN
        checkOutput("sub_ovf_ovf", 32'(res_ovf), 32'(1));
`endif

        // Back-to-back 8 beats, output stalled in cycles 5..9.
        idx       = 0;
        first_low = -1;
        low_cnt   = 0;
        got.delete();
        for (int c = 0; c < 40 && got.size() < 8; c++) begin
            out_ready = !(c >= 5 && c <= 9);
            in_valid  = (idx < 8);
            x         = 16'(idx);
            y         = 16'(idx << 8);
            sub       = 1'b0;
            cin       = 1'b0;
            @(negedge clk);
            if (out_valid && out_ready) got.push_back(sum);
            if (!in_ready) begin
                low_cnt++;
                if (first_low < 0) first_low = c;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("b2b_result_count", 32'(got.size()), 32'(8));
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) checkOutput("b2b_result_order", 32'(got[i]), 32'(257 * i));
        end
        checkOutput("b2b_first_stall_cycle", 32'(first_low), 32'(5));
        checkOutput("b2b_stall_cycles", 32'(low_cnt), 32'(5));
        repeat (4) @(posedge clk);
        #1;

        // Random traffic with random backpressure; the monitor scores each beat.
        n_acc = 0;
        hold  = 1'b0;
        for (int c = 0; c < 40000 && n_acc < 10000; c++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                x        = 16'($urandom);
                y        = 16'($urandom);
                sub      = 1'($urandom_range(0, 1));
                cin      = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) n_acc++;
            hold = in_valid && !acc;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("random_beats_accepted", 32'(n_acc), 32'(10000));
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        // Reset with three beats in flight, oldest one waiting at the output.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            x        = 16'(16'h0101 * (i + 1));
            y        = 16'h0001;
            sub      = 1'b0;
            cin      = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("inflight_out_valid_before_reset", 32'(out_valid), 32'(1));
        rst = 1'b1;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'(0));
        checkOutput("midreset_sum", 32'(sum), 32'(0));
        checkOutput("midreset_cout", 32'(cout), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'(1));
        out_ready = 1'b1;
        stale     = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checkOutput("no_stale_beat_after_reset", 32'(stale), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
